// File: rtl/m_axi_lite_pkg.sv
// m_axi_lite_pkg: shared types and constants for the single-outstanding
// AXI4-Lite master (FSM state encoding and AXI response codes).
package m_axi_lite_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_DATA = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage : m_axi_lite_pkg

// File: rtl/m_axi_lite_if.sv
// m_axi_lite_if: AXI4-Lite bus bundle (AW, W, B, AR, R channels) with
// master and slave modports. The write strobe exists only when the
// M_AXI_LITE_WSTRB_EN macro is defined.
interface m_axi_lite_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   M_AXI_LITE_AWADDR;
    logic                    M_AXI_LITE_AWVALID;
    logic                    M_AXI_LITE_AWREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_LITE_WDATA;
`ifdef M_AXI_LITE_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] M_AXI_LITE_WSTRB;
`endif
    logic                    M_AXI_LITE_WVALID;
    logic                    M_AXI_LITE_WREADY;
    logic [1:0]              M_AXI_LITE_BRESP;
    logic                    M_AXI_LITE_BVALID;
    logic                    M_AXI_LITE_BREADY;
    logic [ADDR_WIDTH-1:0]   M_AXI_LITE_ARADDR;
    logic                    M_AXI_LITE_ARVALID;
    logic                    M_AXI_LITE_ARREADY;
    logic [DATA_WIDTH-1:0]   M_AXI_LITE_RDATA;
    logic [1:0]              M_AXI_LITE_RRESP;
    logic                    M_AXI_LITE_RVALID;
    logic                    M_AXI_LITE_RREADY;

    modport master (
        output M_AXI_LITE_AWADDR, M_AXI_LITE_AWVALID,
        input  M_AXI_LITE_AWREADY,
        output M_AXI_LITE_WDATA,
`ifdef M_AXI_LITE_WSTRB_EN
        output M_AXI_LITE_WSTRB,
`endif
        output M_AXI_LITE_WVALID,
        input  M_AXI_LITE_WREADY,
        input  M_AXI_LITE_BRESP, M_AXI_LITE_BVALID,
        output M_AXI_LITE_BREADY,
        output M_AXI_LITE_ARADDR, M_AXI_LITE_ARVALID,
        input  M_AXI_LITE_ARREADY,
        input  M_AXI_LITE_RDATA, M_AXI_LITE_RRESP, M_AXI_LITE_RVALID,
        output M_AXI_LITE_RREADY
    );

    modport slave (
        input  M_AXI_LITE_AWADDR, M_AXI_LITE_AWVALID,
        output M_AXI_LITE_AWREADY,
        input  M_AXI_LITE_WDATA,
`ifdef M_AXI_LITE_WSTRB_EN
        input  M_AXI_LITE_WSTRB,
`endif
        input  M_AXI_LITE_WVALID,
        output M_AXI_LITE_WREADY,
        output M_AXI_LITE_BRESP, M_AXI_LITE_BVALID,
        input  M_AXI_LITE_BREADY,
        input  M_AXI_LITE_ARADDR, M_AXI_LITE_ARVALID,
        output M_AXI_LITE_ARREADY,
        output M_AXI_LITE_RDATA, M_AXI_LITE_RRESP, M_AXI_LITE_RVALID,
        input  M_AXI_LITE_RREADY
    );

endinterface : m_axi_lite_if

// File: rtl/m_axi_lite.sv
// m_axi_lite: single-outstanding AXI4-Lite master. Turns a local
// command/response handshake into one AXI-Lite read or write at a time.
// Optional feature macro: M_AXI_LITE_WSTRB_EN adds cmd_wstrb and WSTRB.
// Every output comes straight from a flop; output flops are loaded from
// the next-state decode so they line up with the state they belong to.
module m_axi_lite
    import m_axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    M_AXI_ACLK,
    input  logic                    M_AXI_ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_rnw,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
`ifdef M_AXI_LITE_WSTRB_EN
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
`endif
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    m_axi_lite_if.master            m_axi
);

    state_t                  state_q, state_d;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    bready_q, bready_d;
    logic                    arvalid_q, arvalid_d;
    logic                    rready_q, rready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
`ifdef M_AXI_LITE_WSTRB_EN
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic [DATA_WIDTH/8-1:0] wstrb_out_q, wstrb_out_d;
`endif

    // Next-state, capture and registered-output decode.
    always_comb begin
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
`ifdef M_AXI_LITE_WSTRB_EN
        wstrb_d     = wstrb_q;
`endif
        unique case (state_q)
            IDLE: begin
                // cmd_ready_q is low for the first cycle after reset, so
                // gating on it keeps that cycle from accepting anything.
                if (cmd_ready_q && cmd_valid) begin
                    addr_d    = cmd_addr;
                    wdata_d   = cmd_wdata;
`ifdef M_AXI_LITE_WSTRB_EN
                    wstrb_d   = cmd_wstrb;
`endif
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    state_d   = cmd_rnw ? RD_REQ : WR_REQ;
                end
            end
            WR_REQ: begin
                // AW and W complete independently; leave once both have.
                if (awvalid_q && m_axi.M_AXI_LITE_AWREADY) aw_done_d = 1'b1;
                if (wvalid_q && m_axi.M_AXI_LITE_WREADY)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)                 state_d   = WR_RESP;
            end
            WR_RESP: begin
                if (m_axi.M_AXI_LITE_BVALID) begin
                    rsp_resp_d  = m_axi.M_AXI_LITE_BRESP;
                    rsp_rdata_d = '0;
                    state_d     = DONE;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axi.M_AXI_LITE_ARREADY) state_d = RD_DATA;
            end
            RD_DATA: begin
                if (m_axi.M_AXI_LITE_RVALID) begin
                    rsp_rdata_d = m_axi.M_AXI_LITE_RDATA;
                    rsp_resp_d  = m_axi.M_AXI_LITE_RRESP;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        cmd_ready_d = (state_d == IDLE);
        awvalid_d   = (state_d == WR_REQ) && !aw_done_d;
        wvalid_d    = (state_d == WR_REQ) && !w_done_d;
        bready_d    = (state_d == WR_RESP);
        arvalid_d   = (state_d == RD_REQ);
        rready_d    = (state_d == RD_DATA);
        rsp_valid_d = (state_d == DONE);
`ifdef M_AXI_LITE_WSTRB_EN
        wstrb_out_d = wvalid_d ? wstrb_d : '0;
`endif
    end

    // State, capture and output registers with synchronous active-low reset.
    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
`ifdef M_AXI_LITE_WSTRB_EN
            wstrb_q     <= '0;
            wstrb_out_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_ready_q <= cmd_ready_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
`ifdef M_AXI_LITE_WSTRB_EN
            wstrb_q     <= wstrb_d;
            wstrb_out_q <= wstrb_out_d;
`endif
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // One latched address feeds both address channels; only one is ever valid.
    assign m_axi.M_AXI_LITE_AWADDR  = addr_q;
    assign m_axi.M_AXI_LITE_AWVALID = awvalid_q;
    assign m_axi.M_AXI_LITE_WDATA   = wdata_q;
    assign m_axi.M_AXI_LITE_WVALID  = wvalid_q;
    assign m_axi.M_AXI_LITE_BREADY  = bready_q;
    assign m_axi.M_AXI_LITE_ARADDR  = addr_q;
    assign m_axi.M_AXI_LITE_ARVALID = arvalid_q;
    assign m_axi.M_AXI_LITE_RREADY  = rready_q;
`ifdef M_AXI_LITE_WSTRB_EN
    assign m_axi.M_AXI_LITE_WSTRB   = wstrb_out_q;
`endif

endmodule : m_axi_lite

// File: tb/tb_m_axi_lite.sv
// tb_m_axi_lite: directed bench for m_axi_lite. Each transaction is a
// record of slave timing (ready/valid cycles relative to cycle 0 = command
// accepted) from which the expected per-cycle waveform is derived by
// simple cycle arithmetic. Honours M_AXI_LITE_WSTRB_EN when defined.
module tb_m_axi_lite;
    import m_axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    typedef struct {
        bit          rnw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          da;     // AWREADY pulses in cycle 1+da
        int          dw;     // WREADY pulses in cycle 1+dw
        int          bv;     // BVALID raised from this cycle until taken
        logic [1:0]  bresp;
        int          dar;    // ARREADY pulses in cycle 1+dar
        int          rv;     // RVALID raised from this cycle until taken
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          rr;     // rsp_ready raised rr cycles after rsp_valid
    } txn_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cmd_valid, cmd_ready, cmd_rnw;
    logic [31:0] cmd_addr, cmd_wdata;
`ifdef M_AXI_LITE_WSTRB_EN
    logic [3:0]  cmd_wstrb;
`endif
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    int vectors = 0;
    int miscompares = 0;

    // observations for the literal pins
    int          obs_aw, obs_w, obs_rsp, obs_first_rsp, obs_first_bready;
    logic [31:0] obs_rdata;
    logic [1:0]  obs_resp;

    txn_t tl [8];

    always #5 clk = ~clk;

    m_axi_lite_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    m_axi_lite #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .M_AXI_ACLK    (clk),
        .M_AXI_ARESETN (rstn),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_rnw       (cmd_rnw),
        .cmd_addr      (cmd_addr),
        .cmd_wdata     (cmd_wdata),
`ifdef M_AXI_LITE_WSTRB_EN
        .cmd_wstrb     (cmd_wstrb),
`endif
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rdata     (rsp_rdata),
        .rsp_resp      (rsp_resp),
        .m_axi         (bus)
    );

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // First cycle of the response phase.
    function automatic int done_start(input txn_t t);
        if (t.rnw) return max2(2 + t.dar, t.rv) + 1;
        return max2(2 + max2(t.da, t.dw), t.bv) + 1;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
`ifdef M_AXI_LITE_WSTRB_EN
        cmd_wstrb = '0;
`endif
        rsp_ready = 1'b0;
        bus.M_AXI_LITE_AWREADY = 1'b0; bus.M_AXI_LITE_WREADY  = 1'b0;
        bus.M_AXI_LITE_BVALID  = 1'b0; bus.M_AXI_LITE_BRESP   = 2'b00;
        bus.M_AXI_LITE_ARREADY = 1'b0; bus.M_AXI_LITE_RVALID  = 1'b0;
        bus.M_AXI_LITE_RDATA   = '0;   bus.M_AXI_LITE_RRESP   = 2'b00;
    endtask

    task automatic put_cmd(input txn_t t);
        cmd_valid = 1'b1; cmd_rnw = t.rnw; cmd_addr = t.addr; cmd_wdata = t.wdata;
`ifdef M_AXI_LITE_WSTRB_EN
        cmd_wstrb = t.wstrb;
`endif
    endtask

    // Compare every DUT output against what cycle k of transaction t demands.
    task automatic check_cycle(input txn_t t, input int k);
        int  cd, cend, cb, cr;
        bit  e_aw, e_w, e_b, e_ar, e_r, e_rsp;
        cd   = done_start(t);
        cend = cd + t.rr;
        cb   = 2 + max2(t.da, t.dw);
        cr   = 2 + t.dar;
        e_aw  = !t.rnw && k >= 1 && k <= 1 + t.da;
        e_w   = !t.rnw && k >= 1 && k <= 1 + t.dw;
        e_b   = !t.rnw && k >= cb && k < cd;
        e_ar  =  t.rnw && k >= 1 && k <= 1 + t.dar;
        e_r   =  t.rnw && k >= cr && k < cd;
        e_rsp = k >= cd && k <= cend;
        chk("cmd_ready", 32'(cmd_ready), 32'(k == 0));
        chk("awvalid",   32'(bus.M_AXI_LITE_AWVALID), 32'(e_aw));
        chk("wvalid",    32'(bus.M_AXI_LITE_WVALID),  32'(e_w));
        chk("bready",    32'(bus.M_AXI_LITE_BREADY),  32'(e_b));
        chk("arvalid",   32'(bus.M_AXI_LITE_ARVALID), 32'(e_ar));
        chk("rready",    32'(bus.M_AXI_LITE_RREADY),  32'(e_r));
        chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
        if (e_aw) chk("awaddr", bus.M_AXI_LITE_AWADDR, t.addr);
        if (e_w)  chk("wdata",  bus.M_AXI_LITE_WDATA,  t.wdata);
        if (e_ar) chk("araddr", bus.M_AXI_LITE_ARADDR, t.addr);
        if (e_rsp) begin
            chk("rsp_rdata", rsp_rdata, t.rnw ? t.rdata : 32'h0);
            chk("rsp_resp",  32'(rsp_resp), 32'(t.rnw ? t.rresp : t.bresp));
        end
`ifdef M_AXI_LITE_WSTRB_EN
        chk("wstrb", 32'(bus.M_AXI_LITE_WSTRB), 32'(e_w ? t.wstrb : 4'h0));
`endif
        if (bus.M_AXI_LITE_AWVALID === 1'b1) obs_aw++;
        if (bus.M_AXI_LITE_WVALID === 1'b1)  obs_w++;
        if (bus.M_AXI_LITE_BREADY === 1'b1 && obs_first_bready < 0) obs_first_bready = k;
        if (rsp_valid === 1'b1) begin
            obs_rsp++;
            if (obs_first_rsp < 0) begin
                obs_first_rsp = k;
                obs_rdata     = rsp_rdata;
                obs_resp      = rsp_resp;
            end
        end
    endtask

    // Slave and requester inputs for cycle k; nxt >= 0 keeps the next
    // command waiting on cmd_valid throughout this transaction.
    task automatic drive_cycle(input txn_t t, input int k, input int nxt);
        int  cd;
        bit  bvv, rvv;
        cd  = done_start(t);
        bvv = !t.rnw && k >= t.bv && k < cd;
        rvv =  t.rnw && k >= t.rv && k < cd;
        if (k == 0)        put_cmd(t);
        else if (nxt >= 0) put_cmd(tl[nxt]);
        else               cmd_valid = 1'b0;
        bus.M_AXI_LITE_AWREADY = !t.rnw && k == 1 + t.da;
        bus.M_AXI_LITE_WREADY  = !t.rnw && k == 1 + t.dw;
        bus.M_AXI_LITE_BVALID  = bvv;
        bus.M_AXI_LITE_BRESP   = bvv ? t.bresp : 2'b11;
        bus.M_AXI_LITE_ARREADY = t.rnw && k == 1 + t.dar;
        bus.M_AXI_LITE_RVALID  = rvv;
        bus.M_AXI_LITE_RDATA   = rvv ? t.rdata : 32'hBAD0_BAD0;
        bus.M_AXI_LITE_RRESP   = rvv ? t.rresp : 2'b11;
        rsp_ready = (k == cd + t.rr);
    endtask

    // Called at the negedge of cycle 0; returns at the negedge after the
    // response is consumed (or right after checking cycle stop_k).
    task automatic run_txn(input int i, input int nxt, input int stop_k);
        int last;
        last = done_start(tl[i]) + tl[i].rr;
        obs_aw = 0; obs_w = 0; obs_rsp = 0; obs_first_rsp = -1; obs_first_bready = -1;
        obs_rdata = '0; obs_resp = '0;
        for (int k = 0; k <= last; k++) begin
            check_cycle(tl[i], k);
            if (stop_k >= 0 && k == stop_k) return;
            drive_cycle(tl[i], k, nxt);
            @(negedge clk);
        end
        $display("txn %0d %s addr=%h done: rsp@%0d resp=%0d rdata=%h", i,
                 tl[i].rnw ? "RD" : "WR", tl[i].addr, obs_first_rsp, obs_resp, obs_rdata);
    endtask

    initial begin
        //            rnw addr          wdata         strb da dw bv bresp dar rv  rdata         rresp rr
        tl[0] = '{1'b0, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 2, 2'b00, 0, 0, 32'h0,         2'b00, 0};
        tl[1] = '{1'b0, 32'h0000_0008, 32'hCAFE_F00D, 4'h3, 0, 3, 2, 2'b10, 0, 0, 32'h0,         2'b00, 0};
        tl[2] = '{1'b1, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 2'b00, 0, 4, 32'h1234_5678, 2'b10, 5};
        tl[3] = '{1'b1, 32'h0000_0020, 32'h0,         4'h0, 0, 0, 0, 2'b00, 2, 1, 32'hA5A5_5A5A, 2'b00, 0};
        tl[4] = '{1'b0, 32'h0000_0003, 32'h0000_0001, 4'hC, 2, 0, 6, 2'b11, 0, 0, 32'h0,         2'b00, 1};
        tl[5] = '{1'b1, 32'hFFFF_FFFC, 32'h0,         4'h0, 0, 0, 0, 2'b00, 1, 3, 32'h0,         2'b01, 0};
        tl[6] = '{1'b1, 32'h0000_0050, 32'h0,         4'h0, 0, 0, 0, 2'b00, 100, 200, 32'h0,     2'b00, 0};
        tl[7] = '{1'b0, 32'h0000_0040, 32'h1122_3344, 4'h5, 1, 1, 3, 2'b00, 0, 0, 32'h0,         2'b00, 0};

        idle_inputs();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_awvalid",   32'(bus.M_AXI_LITE_AWVALID), 32'h0);
        chk("rst_wvalid",    32'(bus.M_AXI_LITE_WVALID),  32'h0);
        chk("rst_bready",    32'(bus.M_AXI_LITE_BREADY),  32'h0);
        chk("rst_arvalid",   32'(bus.M_AXI_LITE_ARVALID), 32'h0);
        chk("rst_rready",    32'(bus.M_AXI_LITE_RREADY),  32'h0);
        chk("rst_awaddr",    bus.M_AXI_LITE_AWADDR, 32'h0);
        chk("rst_wdata",     bus.M_AXI_LITE_WDATA,  32'h0);
        chk("rst_araddr",    bus.M_AXI_LITE_ARADDR, 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_resp",  32'(rsp_resp), 32'h0);
`ifdef M_AXI_LITE_WSTRB_EN
        chk("rst_wstrb",     32'(bus.M_AXI_LITE_WSTRB), 32'h0);
`endif
        rstn = 1'b1;
        @(negedge clk);

        run_txn(0, 1, -1);
        chk("t0_first_rsp_cycle", 32'(obs_first_rsp), 32'd3);
        chk("t0_aw_cycles", 32'(obs_aw), 32'd1);
        chk("t0_w_cycles",  32'(obs_w),  32'd1);
        run_txn(1, 2, -1);
        chk("t1_aw_cycles", 32'(obs_aw), 32'd1);
        chk("t1_w_cycles",  32'(obs_w),  32'd4);
        chk("t1_first_bready", 32'(obs_first_bready), 32'd5);
        run_txn(2, 3, -1);
        chk("t2_rdata", obs_rdata, 32'h1234_5678);
        chk("t2_resp",  32'(obs_resp), 32'h2);
        chk("t2_first_rsp_cycle", 32'(obs_first_rsp), 32'd5);
        chk("t2_rsp_cycles", 32'(obs_rsp), 32'd6);
        run_txn(3, 4, -1);
        run_txn(4, 5, -1);
        run_txn(5, -1, -1);

        // Reset while ARVALID waits on an ARREADY that never comes.
        run_txn(6, -1, 3);
        idle_inputs();
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_arvalid",   32'(bus.M_AXI_LITE_ARVALID), 32'h0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_cmd_ready", 32'(cmd_ready), 32'h0);
        chk("mid_rst_state",     32'(dut.state_q), 32'(IDLE));
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        run_txn(7, -1, -1);
        chk("t7_first_rsp_cycle", 32'(obs_first_rsp), 32'd4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_m_axi_lite
